// File: rtl/lif_pkg.sv
// ----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the time-multiplexed leaky integrate-and-fire block:
// default widths/threshold, the scheduler FSM state type and a saturating
// adder used by the update datapath.
// No ports (package).
// ----------------------------------------------------------------------------
package lif_pkg;

   localparam int WIDTH_DEFAULT  = 8;
   localparam int THRESH_DEFAULT = 200;

   // Scheduler sequencing: waiting for a tick, updating one neuron per cycle,
   // or holding a spike event until downstream takes it.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      EMIT   = 2'd2
   } fsmState_e;

   // Adds two unsigned values and clamps the result to the largest value that
   // fits in 'width' bits. The extra carry bit makes overflow visible so the
   // membrane potential pins at full scale instead of wrapping to a small value.
   function automatic logic [31:0] satAdd(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
      logic [32:0] sum;
      logic [32:0] maxVal;
      sum    = {1'b0, a} + {1'b0, b};
      maxVal = (33'd1 << width) - 33'd1;
      return (sum > maxVal) ? maxVal[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/lif_update.sv
// ----------------------------------------------------------------------------
// lif_update
// Purely combinational single-neuron LIF step: leaks the membrane state by a
// right shift, adds the pending input current with saturation, and compares
// against the threshold.
// Ports:
//   cur_i        pending input current of the neuron being updated
//   state_i      current membrane state of that neuron
//   thr_i        firing threshold
//   nextState_o  state to store back (zero when the neuron fires)
//   fire_o       high when the saturated sum reaches the threshold
// ----------------------------------------------------------------------------
module lif_update
   import lif_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEFAULT,
   parameter int LEAK_SHIFT = 1
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] state_i,
   input  logic [WIDTH-1:0] thr_i,
   output logic [WIDTH-1:0] nextState_o,
   output logic             fire_o
);

   logic [WIDTH-1:0] leaked;
   logic [WIDTH-1:0] sum;

   // Leak, integrate, compare. A firing neuron resets to zero, so the value
   // written back is chosen here rather than in the scheduler.
   always_comb begin
      leaked      = state_i >> LEAK_SHIFT;
      sum         = WIDTH'(satAdd(32'(cur_i), 32'(leaked), WIDTH));
      fire_o      = (sum >= thr_i);
      nextState_o = fire_o ? '0 : sum;
   end

endmodule

// File: rtl/lif_scheduler.sv
// ----------------------------------------------------------------------------
// lif_scheduler
// Shares one lif_update datapath across N_NEURONS neurons. Each tick starts a
// sweep that updates neurons 0..N_NEURONS-1 in order, one per cycle; a firing
// neuron pauses the sweep until its spike event is accepted downstream.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   tick_i              starts one sweep when idle
//   busy_o              high while a sweep is in progress
//   cur_we_i/addr/data  overwrite pending input current of one neuron
//   thr_we_i/thr_data_i load a new firing threshold
//   spk_valid_o/ready_i spike event handshake
//   spk_id_o            id of the spiking neuron
//   st_rd_addr_i/data_o combinational debug read of membrane state
//   overrun_o           sticky flag: tick seen while busy
// ----------------------------------------------------------------------------
module lif_scheduler
   import lif_pkg::*;
#(
   parameter  int N_NEURONS  = 4,
   parameter  int WIDTH      = WIDTH_DEFAULT,
   parameter  int THRESH_RST = THRESH_DEFAULT,
   parameter  int LEAK_SHIFT = 1,
   localparam int AW         = $clog2(N_NEURONS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick_i,
   output logic             busy_o,
   input  logic             cur_we_i,
   input  logic [AW-1:0]    cur_addr_i,
   input  logic [WIDTH-1:0] cur_data_i,
   input  logic             thr_we_i,
   input  logic [WIDTH-1:0] thr_data_i,
   output logic             spk_valid_o,
   input  logic             spk_ready_i,
   output logic [AW-1:0]    spk_id_o,
   input  logic [AW-1:0]    st_rd_addr_i,
   output logic [WIDTH-1:0] st_rd_data_o,
   output logic             overrun_o
);

   fsmState_e        fsm_q, fsm_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             spkValid_q, spkValid_d;
   logic [AW-1:0]    spkId_q, spkId_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] thr_q, thr_d;
   logic [WIDTH-1:0] state_q [N_NEURONS];
   logic [WIDTH-1:0] state_d [N_NEURONS];
   logic [WIDTH-1:0] cur_q [N_NEURONS];
   logic [WIDTH-1:0] cur_d [N_NEURONS];

   logic [WIDTH-1:0] updNext;
   logic             updFire;
   logic             lastIdx;

   assign lastIdx = (idx_q == AW'(N_NEURONS - 1));

   // The single shared datapath always looks at the neuron under the sweep
   // index; its result is only used while in UPDATE.
   lif_update #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .cur_i       (cur_q[idx_q]),
      .state_i     (state_q[idx_q]),
      .thr_i       (thr_q),
      .nextState_o (updNext),
      .fire_o      (updFire)
   );

   // State register for the sequencer plus the per-neuron storage. Reset
   // clears everything at once, so a sweep or pending spike is simply
   // abandoned.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q      <= IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         spkValid_q <= 1'b0;
         spkId_q    <= '0;
         overrun_q  <= 1'b0;
         thr_q      <= WIDTH'(THRESH_RST);
         for (int i = 0; i < N_NEURONS; i++) begin
            state_q[i] <= '0;
            cur_q[i]   <= '0;
         end
      end else begin
         fsm_q      <= fsm_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         spkValid_q <= spkValid_d;
         spkId_q    <= spkId_d;
         overrun_q  <= overrun_d;
         thr_q      <= thr_d;
         for (int i = 0; i < N_NEURONS; i++) begin
            state_q[i] <= state_d[i];
            cur_q[i]   <= cur_d[i];
         end
      end
   end

   // Sequencer next-state logic. A firing neuron leaves the index where it is
   // so EMIT knows whether the spike came from the last neuron; the index
   // only advances once the event has been handed off.
   always_comb begin
      fsm_d      = fsm_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      spkValid_d = spkValid_q;
      spkId_d    = spkId_q;
      overrun_d  = overrun_q;
      unique case (fsm_q)
         IDLE: begin
            if (tick_i) begin
               fsm_d  = UPDATE;
               idx_d  = '0;
               busy_d = 1'b1;
            end
         end
         UPDATE: begin
            if (updFire) begin
               spkValid_d = 1'b1;
               spkId_d    = idx_q;
               fsm_d      = EMIT;
            end else if (lastIdx) begin
               fsm_d  = IDLE;
               busy_d = 1'b0;
               idx_d  = '0;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         EMIT: begin
            if (spkValid_q && spk_ready_i) begin
               spkValid_d = 1'b0;
               if (lastIdx) begin
                  fsm_d  = IDLE;
                  busy_d = 1'b0;
                  idx_d  = '0;
               end else begin
                  fsm_d = UPDATE;
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         default: begin
            fsm_d      = IDLE;
            busy_d     = 1'b0;
            spkValid_d = 1'b0;
         end
      endcase
      if (tick_i && busy_q) begin
         overrun_d = 1'b1;
      end
   end

   // Per-neuron storage updates. The update clear of the current comes first
   // so that a host write to the same neuron in the same cycle overrides it
   // and the new current is kept for the next sweep.
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         state_d[i] = state_q[i];
         cur_d[i]   = cur_q[i];
      end
      if (fsm_q == UPDATE) begin
         state_d[idx_q] = updNext;
         cur_d[idx_q]   = '0;
      end
      if (cur_we_i) begin
         cur_d[cur_addr_i] = cur_data_i;
      end
      thr_d = thr_we_i ? thr_data_i : thr_q;
   end

   // Outputs come straight from registers, except the debug read port which
   // is a plain combinational mux over the state array.
   always_comb begin
      busy_o       = busy_q;
      spk_valid_o  = spkValid_q;
      spk_id_o     = spkId_q;
      overrun_o    = overrun_q;
      st_rd_data_o = state_q[st_rd_addr_i];
   end

endmodule
